// File: rtl/gemm_tile_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : gemm_tile_scheduler_if
// Description : Bundle of the operand-load, result-return and GEMM-side
//               signals of gemm_tile_scheduler.
//   in_valid/in_ready    operand handshake (a_in, b_in: N*N*DW, row-major)
//   gemm_a/gemm_b        2x2 operand tiles to the GEMM (4*DW)
//   gemm_out             2x2 result tile from the GEMM (4*DW)
//   out_valid/out_ready  result handshake (c_out: N*N*DW, row-major)
//   busy                 scheduler is issuing or draining
//   modport slave  : the scheduler side
//   modport master : the surrounding system (loader, GEMM, consumer)
// Revision    : 1.0 - initial release
// ============================================================================
interface gemm_tile_scheduler_if #(
  parameter int DW = 32,
  parameter int N  = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [N*N*DW-1:0]   a_in;
  logic [N*N*DW-1:0]   b_in;
  logic [4*DW-1:0]     gemm_a;
  logic [4*DW-1:0]     gemm_b;
  logic [4*DW-1:0]     gemm_out;
  logic                out_valid;
  logic                out_ready;
  logic [N*N*DW-1:0]   c_out;
  logic                busy;

  modport slave (
    input  in_valid, a_in, b_in, gemm_out, out_ready,
    output in_ready, gemm_a, gemm_b, out_valid, c_out, busy
  );

  modport master (
    output in_valid, a_in, b_in, gemm_out, out_ready,
    input  in_ready, gemm_a, gemm_b, out_valid, c_out, busy
  );
endinterface
`default_nettype wire

// File: rtl/gemm_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : gemm_tile_scheduler
// Description : Computes C = A*B (N x N, unsigned, mod 2^DW) by issuing
//               (N/2)^3 2x2 tile products to one shared fixed-latency GEMM,
//               tracking returns with a LAT-deep valid/tag pipe and summing
//               the partial tiles into C accumulators.
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   gemm_tile_scheduler_if.slave (operand/result handshakes, GEMM tiles)
// Revision    : 1.0 - initial release
// ============================================================================
module gemm_tile_scheduler #(
  parameter int DW  = 32,
  parameter int N   = 4,
  parameter int LAT = 6
) (
  input wire clk,
  input wire rst,
  gemm_tile_scheduler_if.slave bus
);
  localparam int T  = N / 2;
  localparam int T3 = T * T * T;
  localparam int IW = (T > 1) ? $clog2(T) : 1;
  localparam int CW = $clog2(T3 + 1);
  localparam int MW = N * N * DW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    r_state;
  logic          r_alive;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_rcnt;
  logic [MW-1:0] r_a;
  logic [MW-1:0] r_b;
  logic [MW-1:0] r_c;
  logic [DW-1:0] r_acc [N*N];
  logic [DW-1:0] w_acc_next [N*N];

  // Valid/tag pipe: tag is {i, j, k==0} of the issued tile product.
  logic [LAT-1:0] r_pv;
  logic [LAT-1:0] r_pk0;
  logic [IW-1:0]  r_pi [LAT];
  logic [IW-1:0]  r_pj [LAT];

  logic [IW-1:0]  w_ci, w_cj, w_ck;
  logic [4*DW-1:0] w_ga, w_gb;
  logic w_in_ready, w_accept, w_tail, w_last, w_rest, w_enter_done;

  // Issue counter decomposes as i*T*T + j*T + k, so k runs innermost.
  assign w_ck = IW'(int'(r_cnt) % T);
  assign w_cj = IW'((int'(r_cnt) / T) % T);
  assign w_ci = IW'(int'(r_cnt) / (T * T));

  // r_alive keeps in_ready low while reset is asserted and until the first
  // edge after release.
  assign w_in_ready   = (r_state == S_IDLE) && r_alive;
  assign w_accept     = w_in_ready && bus.in_valid;
  assign w_tail       = r_pv[LAT-1];
  assign w_last       = w_tail && (r_rcnt == CW'(T3 - 1));
  assign w_enter_done = (r_state == S_DRAIN) && w_last && !w_rest;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign bus.c_out     = r_c;
  assign bus.gemm_a    = w_ga;
  assign bus.gemm_b    = w_gb;

  // Any valid entry other than the tail still in flight.
  always_comb begin
    w_rest = 1'b0;
    for (int s = 0; s < LAT - 1; s++) w_rest = w_rest | r_pv[s];
  end

  // Tile select written as a compare-and-pick over constant tile positions so
  // every operand slice is a fixed bit range.
  always_comb begin
    w_ga = '0;
    w_gb = '0;
    if (r_state == S_ISSUE) begin
      for (int ti = 0; ti < T; ti++) begin
        for (int tk = 0; tk < T; tk++) begin
          for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
              if (w_ci == IW'(ti) && w_ck == IW'(tk))
                w_ga[(2*r+c)*DW +: DW] = r_a[((2*ti+r)*N + 2*tk+c)*DW +: DW];
              if (w_ck == IW'(ti) && w_cj == IW'(tk))
                w_gb[(2*r+c)*DW +: DW] = r_b[((2*ti+r)*N + 2*tk+c)*DW +: DW];
            end
          end
        end
      end
    end
  end

  // Absorb the returning tile: k==0 overwrites, later k accumulate.
  always_comb begin
    for (int e = 0; e < N * N; e++) w_acc_next[e] = r_acc[e];
    if (w_tail) begin
      for (int ti = 0; ti < T; ti++) begin
        for (int tj = 0; tj < T; tj++) begin
          for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
              if (r_pi[LAT-1] == IW'(ti) && r_pj[LAT-1] == IW'(tj))
                w_acc_next[(2*ti+r)*N + 2*tj+c] =
                  (r_pk0[LAT-1] ? '0 : r_acc[(2*ti+r)*N + 2*tj+c]) +
                  bus.gemm_out[(2*r+c)*DW +: DW];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_alive <= 1'b0;
      r_cnt   <= '0;
      r_rcnt  <= '0;
    end else begin
      r_alive <= 1'b1;
      if (w_tail) r_rcnt <= r_rcnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt   <= '0;
            r_rcnt  <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(T3 - 1)) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_enter_done) r_state <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pv  <= '0;
      r_pk0 <= '0;
      for (int s = 0; s < LAT; s++) begin
        r_pi[s] <= '0;
        r_pj[s] <= '0;
      end
    end else begin
      r_pv[0]  <= (r_state == S_ISSUE);
      r_pk0[0] <= (w_ck == '0);
      r_pi[0]  <= w_ci;
      r_pj[0]  <= w_cj;
      for (int s = 1; s < LAT; s++) begin
        r_pv[s]  <= r_pv[s-1];
        r_pk0[s] <= r_pk0[s-1];
        r_pi[s]  <= r_pi[s-1];
        r_pj[s]  <= r_pj[s-1];
      end
    end
  end

  // c_out takes the accumulators including the final absorption so it is
  // complete on the same edge that enters DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < N * N; e++) r_acc[e] <= '0;
      r_c <= '0;
    end else begin
      for (int e = 0; e < N * N; e++) r_acc[e] <= w_acc_next[e];
      if (w_enter_done) begin
        for (int e = 0; e < N * N; e++) r_c[e*DW +: DW] <= w_acc_next[e];
      end
    end
  end

  // Operand holding registers need no reset: they are only read during ISSUE,
  // which is always preceded by a capture.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= bus.a_in;
      r_b <= bus.b_in;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_gemm_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_gemm_tile_scheduler
// Description : Directed self-checking bench for gemm_tile_scheduler with a
//               behavioural LAT-stage, unreset 2x2 GEMM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gemm_tile_scheduler;
  localparam int DW  = 32;
  localparam int N   = 4;
  localparam int LAT = 6;
  localparam int MW  = N * N * DW;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  int   lat;

  logic [MW-1:0] m_ident, m_seq, m_arc, m_brc, m_allf, m_exp;
  logic [DW-1:0] elem;

  gemm_tile_scheduler_if #(.DW(DW), .N(N)) bus ();

  gemm_tile_scheduler #(.DW(DW), .N(N), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 2x2 GEMM model: LAT register stages, no reset.
  logic [4*DW-1:0] gpipe [LAT];

  function automatic logic [4*DW-1:0] mul2(input logic [4*DW-1:0] a, b);
    logic [4*DW-1:0] p;
    logic [DW-1:0]   s;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        s = '0;
        for (int k = 0; k < 2; k++)
          s = s + a[(2*r+k)*DW +: DW] * b[(2*k+c)*DW +: DW];
        p[(2*r+c)*DW +: DW] = s;
      end
    return p;
  endfunction

  always @(posedge clk) begin
    gpipe[0] <= mul2(bus.gemm_a, bus.gemm_b);
    for (int s = 1; s < LAT; s++) gpipe[s] <= gpipe[s-1];
  end
  assign bus.gemm_out = gpipe[LAT-1];

  // Plain row-column reference product.
  function automatic logic [MW-1:0] ref_mm(input logic [MW-1:0] a, b);
    logic [MW-1:0] c;
    logic [DW-1:0] s;
    for (int r = 0; r < N; r++)
      for (int cc = 0; cc < N; cc++) begin
        s = '0;
        for (int k = 0; k < N; k++)
          s = s + a[(r*N+k)*DW +: DW] * b[(k*N+cc)*DW +: DW];
        c[(r*N+cc)*DW +: DW] = s;
      end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready (bounded), presents operands for exactly one edge.
  task automatic start_job(input logic [MW-1:0] a, input logic [MW-1:0] b);
    int g;
    g = 0;
    while (!bus.in_ready && g < 50) begin
      step();
      g++;
    end
    chk("in_ready_before_accept", MW'(bus.in_ready), MW'(1));
    bus.a_in     = a;
    bus.b_in     = b;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Counts edges until out_valid is seen; 60 means it never came.
  task automatic wait_out(input int start, output int n);
    n = start;
    while (!bus.out_valid && n < 60) begin
      step();
      n++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        m_ident[(r*N+c)*DW +: DW] = (r == c) ? DW'(1) : DW'(0);
        m_seq[(r*N+c)*DW +: DW]   = DW'(4*r + c + 1);
        m_arc[(r*N+c)*DW +: DW]   = DW'(r + c);
        m_brc[(r*N+c)*DW +: DW]   = DW'(r * c);
        m_allf[(r*N+c)*DW +: DW]  = {DW{1'b1}};
      end

    // Reset release
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    step();
    step();
    chk("rst_in_ready", MW'(bus.in_ready), MW'(0));
    chk("rst_out_valid", MW'(bus.out_valid), MW'(0));
    rst = 1'b1;
    step();
    chk("rel_in_ready", MW'(bus.in_ready), MW'(1));
    chk("rel_out_valid", MW'(bus.out_valid), MW'(0));
    chk("rel_busy", MW'(bus.busy), MW'(0));
    chk("rel_gemm_a", MW'(bus.gemm_a), MW'(0));
    chk("rel_gemm_b", MW'(bus.gemm_b), MW'(0));

    // Identity: C = B, out_valid 14 edges after accept
    bus.out_ready = 1'b1;
    start_job(m_ident, m_seq);
    chk("id_busy", MW'(bus.busy), MW'(1));
    chk("id_in_ready", MW'(bus.in_ready), MW'(0));
    chk("id_gemm_a0", MW'(bus.gemm_a), MW'({32'd1, 32'd0, 32'd0, 32'd1}));
    chk("id_gemm_b0", MW'(bus.gemm_b), MW'({32'd6, 32'd5, 32'd2, 32'd1}));
    step();
    chk("id_gemm_a1", MW'(bus.gemm_a), MW'(0));
    chk("id_gemm_b1", MW'(bus.gemm_b), MW'({32'd14, 32'd13, 32'd10, 32'd9}));
    wait_out(1, lat);
    chk("id_latency", MW'(lat), MW'(14));
    chk("id_c_out", bus.c_out, m_seq);
    chk("id_busy_done", MW'(bus.busy), MW'(0));
    step();
    chk("id_hs_out_valid", MW'(bus.out_valid), MW'(0));
    chk("id_hs_in_ready", MW'(bus.in_ready), MW'(1));
    chk("id_hold_c_out", bus.c_out, m_seq);

    // Known product: C[r][c] = sum_k (r+k)*k*c
    start_job(m_arc, m_brc);
    wait_out(0, lat);
    chk("kp_latency", MW'(lat), MW'(14));
    m_exp = ref_mm(m_arc, m_brc);
    chk("kp_c_out", bus.c_out, m_exp);
    elem = bus.c_out[(1*N+2)*DW +: DW];
    chk("kp_c12", MW'(elem), MW'(40));
    elem = bus.c_out[(3*N+3)*DW +: DW];
    chk("kp_c33", MW'(elem), MW'(96));
    elem = bus.c_out[(0*N+0)*DW +: DW];
    chk("kp_c00", MW'(elem), MW'(0));
    step();

    // Wrap-around: 4 * (2^32-1)^2 mod 2^32 = 4
    start_job(m_allf, m_allf);
    wait_out(0, lat);
    chk("wr_latency", MW'(lat), MW'(14));
    chk("wr_c_out", bus.c_out, {(N*N){32'h0000_0004}});
    step();

    // Backpressure with ignored operands
    bus.out_ready = 1'b0;
    start_job(m_seq, m_ident);
    bus.a_in     = m_allf;
    bus.b_in     = m_allf;
    bus.in_valid = 1'b1;
    wait_out(0, lat);
    chk("bp_latency", MW'(lat), MW'(14));
    chk("bp_c_out", bus.c_out, m_seq);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_out_valid", MW'(bus.out_valid), MW'(1));
      chk("bp_hold_in_ready", MW'(bus.in_ready), MW'(0));
      chk("bp_hold_c_out", bus.c_out, m_seq);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("bp_hs_out_valid", MW'(bus.out_valid), MW'(0));
    chk("bp_hs_in_ready", MW'(bus.in_ready), MW'(1));

    // Mid-job reset during DRAIN, then a clean identity job
    start_job(m_arc, m_brc);
    for (int i = 0; i < 10; i++) step();
    chk("mr_busy_drain", MW'(bus.busy), MW'(1));
    chk("mr_gemm_a_drain", MW'(bus.gemm_a), MW'(0));
    rst = 1'b0;
    #1;
    chk("mr_rst_out_valid", MW'(bus.out_valid), MW'(0));
    chk("mr_rst_busy", MW'(bus.busy), MW'(0));
    chk("mr_rst_in_ready", MW'(bus.in_ready), MW'(0));
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("mr_idle_out_valid", MW'(bus.out_valid), MW'(0));
    end
    start_job(m_ident, m_seq);
    wait_out(0, lat);
    chk("mr_latency", MW'(lat), MW'(14));
    chk("mr_c_out", bus.c_out, m_seq);
    step();
    chk("mr_hs_out_valid", MW'(bus.out_valid), MW'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
